button_event_arbiter: RTL and testbench
=======================================

BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 Parameter NUM_BTN, default 4, number of push-button channels; legal range 2..8.
REQ-002 Parameter DEBOUNCE_CYCLES, default 2_500_000, consecutive stable cycles required to accept a level change (20 ms at 125 MHz); the bench overrides it to 4.
REQ-003 Port clk, input, 1, single system clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 Port btn_raw, input, NUM_BTN, asynchronous raw button levels, active-high.
REQ-006 Port evt_ready, input, 1, consumer accepts the offered event.
REQ-007 Port evt_valid, output, 1, an event is offered.
REQ-008 Port evt_id, output, $clog2(NUM_BTN), index of the offered button.
REQ-009 Port evt_drop, output, 1, one-cycle pulse when a press is lost.
REQ-010 Port btn_level, output, NUM_BTN, debounced button levels.

Function
REQ-011 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Per channel, the debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle SHALL clear that channel's counter.
REQ-013 A 0->1 transition of a debounced level SHALL set that channel's pending bit one cycle later; 1->0 transitions SHALL generate no event.
REQ-014 A press SHALL yield exactly one event regardless of hold time or bounce shorter than DEBOUNCE_CYCLES.
REQ-015 The FSM SHALL have two states: IDLE (evt_valid=0) and OFFER (evt_valid=1).
REQ-016 IDLE with pending!=0 SHALL go to OFFER, latch evt_id as the first pending index at or after the round-robin pointer (wrapping modulo NUM_BTN), and clear that pending bit.
REQ-017 OFFER SHALL hold evt_valid and evt_id stable until evt_valid & evt_ready, then return to IDLE and set pointer = (evt_id+1) mod NUM_BTN.
REQ-018 Throughput SHALL be at most one event per 2 cycles.
REQ-019 With an idle arbiter and nothing pending, evt_valid SHALL be high in the cycle after edge DEBOUNCE_CYCLES+4, where edge 1 is the first edge that samples the new raw level.
REQ-020 A new rising edge on a channel whose pending bit is already set SHALL be discarded and SHALL pulse evt_drop for one cycle.
REQ-021 If a new rising edge coincides with the grant-clear of the same channel, the set SHALL win (a second event).
REQ-022 A press on the channel currently in OFFER SHALL set pending normally and is not a drop.

Reset
REQ-023 While rst=0 at a clock edge, the block SHALL set FSM=IDLE, pending=0, pointer=0, all debounce counters=0, synchronizers and debounced levels=0, evt_valid=0, evt_id=0, evt_drop=0, and btn_level=0.
REQ-024 Reset asserted mid-OFFER SHALL abort the offer; evt_valid=0 from the next cycle and no event is replayed.

Structure
REQ-025 Package guess_game_pkg SHALL hold arb_state_t (IDLE, OFFER) and the DEBOUNCE_CYCLES default constant.
REQ-026 Sub-module button_debouncer (synchronizer, counter, debounced level, rising-edge flag, one channel) SHALL be instantiated NUM_BTN times via generate.
REQ-027 Round-robin selection, pending register, FSM and drop logic SHALL reside in button_event_arbiter.

Verification (DEBOUNCE_CYCLES=4, NUM_BTN=4)
REQ-028 Reset: rst=0 for 3 cycles with btn_raw=4'hF -> evt_valid=0, evt_id=0, evt_drop=0, btn_level=0 throughout.
REQ-029 Clean press: btn_raw[2] held high 50 cycles, evt_ready=1 -> evt_valid high for exactly one cycle after edge 8 with evt_id=2; release produces no event; btn_level[2] follows.
REQ-030 Bounce: btn_raw[1] toggles every 2 cycles for 20 cycles, then stays high -> exactly one event, evt_id=1.
REQ-031 Round-robin: press 1 alone (pointer->2), then press 0 and 3 in the same cycle, evt_ready=1 -> events evt_id=3, then evt_id=0.
REQ-032 Backpressure: evt_ready=0; press 0 (offered), press 0 again (pending), press 0 a third time -> one-cycle evt_drop=1, evt_valid/evt_id=0 stable; raise evt_ready -> exactly two events with id 0.
REQ-033 Reset mid-OFFER: rst=0 for one cycle during OFFER with evt_ready=0 -> evt_valid=0 next cycle, pending cleared, next single press of 3 yields evt_id=3 with pointer restarted at 0.

Source files
------------

// File: rtl/guess_game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : guess_game_pkg
// Description : Shared types and constants for the push-button event path.
//               Holds the arbiter state encoding and the default debounce
//               window (20 ms at 125 MHz).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package guess_game_pkg;

  localparam int unsigned c_DEBOUNCE_CYCLES = 2_500_000;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

endpackage : guess_game_pkg
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : One push-button channel: 2-flop synchronizer, stability
//               counter, debounced level and a registered rising-edge flag.
// Ports       : clk       - system clock, rising edge
//               rst       - synchronous reset, active low
//               btn_raw   - asynchronous raw button level, active high
//               level     - debounced level
//               rise      - one-cycle pulse, registered with the 0->1 change
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer
  import guess_game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  // The counter only has to reach DEBOUNCE_CYCLES-1; the flip happens on the
  // edge that would make it DEBOUNCE_CYCLES.
  localparam int unsigned c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]         r_sync;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_level;
  logic               r_rise;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], btn_raw};
      r_rise <= 1'b0;
      if (r_sync[1] == r_level) begin
        // Any agreeing cycle restarts the stability window.
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
        r_rise  <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;

endmodule : button_debouncer
`default_nettype wire

// File: rtl/button_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : button_event_arbiter
// Description : Debounces NUM_BTN push buttons and turns each press into one
//               valid/ready event, arbitrated round-robin. A press arriving
//               while its channel already has an event pending is dropped
//               and flagged on evt_drop.
// Ports       : clk       - system clock, rising edge
//               rst       - synchronous reset, active low
//               btn_raw   - raw button levels, active high, asynchronous
//               evt_ready - consumer accepts the offered event
//               evt_valid - an event is offered
//               evt_id    - index of the offered button
//               evt_drop  - one-cycle pulse when a press is lost
//               btn_level - debounced button levels
// Revision    : 1.0 - initial release
// ============================================================================
module button_event_arbiter
  import guess_game_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_BTN-1:0]         btn_raw,
  input  logic                       evt_ready,
  output logic                       evt_valid,
  output logic [$clog2(NUM_BTN)-1:0] evt_id,
  output logic                       evt_drop,
  output logic [NUM_BTN-1:0]         btn_level
);

  localparam int unsigned c_ID_W  = $clog2(NUM_BTN);
  localparam int unsigned c_SUM_W = c_ID_W + 1;
  localparam logic [c_SUM_W-1:0] c_NUM    = c_SUM_W'(NUM_BTN);
  localparam logic [c_ID_W-1:0]  c_ID_MAX = c_ID_W'(NUM_BTN - 1);

  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] w_rise;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_debounce
      button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debouncer (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw[gi]),
        .level  (w_level[gi]),
        .rise   (w_rise[gi])
      );
    end
  endgenerate

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [NUM_BTN-1:0] r_pend;
  logic [NUM_BTN-1:0] w_pend_nxt;
  logic [c_ID_W-1:0]  r_ptr;
  logic [c_ID_W-1:0]  w_ptr_nxt;
  logic [c_ID_W-1:0]  r_id;
  logic [c_ID_W-1:0]  w_id_nxt;
  logic               r_drop;
  logic               w_drop_nxt;
  logic [NUM_BTN-1:0] w_grant;

  // Round-robin pick: first pending index at or after r_ptr, wrapping.
  // Scanning from the far end lets the nearest hit overwrite the others.
  logic               w_found;
  logic [c_ID_W-1:0]  w_sel;
  logic [c_SUM_W-1:0] w_sum;
  logic [c_ID_W-1:0]  w_idx;

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = NUM_BTN - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + c_SUM_W'(k);
      w_idx = (w_sum >= c_NUM) ? c_ID_W'(w_sum - c_NUM) : c_ID_W'(w_sum);
      if (r_pend[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_id_nxt    = r_id;
    w_grant     = '0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt    = OFFER;
          w_id_nxt       = w_sel;
          w_grant[w_sel] = 1'b1;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = (r_id == c_ID_MAX) ? '0 : r_id + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // A new press landing on the same cycle as its own grant-clear survives
    // as a fresh pending event; only a press on a still-pending bit is lost.
    w_pend_nxt = (r_pend & ~w_grant) | w_rise;
    w_drop_nxt = |(w_rise & r_pend & ~w_grant);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_ptr   <= '0;
      r_id    <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_ptr   <= w_ptr_nxt;
      r_id    <= w_id_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  assign evt_valid = (r_state == OFFER);
  assign evt_id    = r_id;
  assign evt_drop  = r_drop;
  assign btn_level = w_level;

endmodule : button_event_arbiter
`default_nettype wire

// File: tb/tb_button_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_event_arbiter
// Description : Self-checking bench for button_event_arbiter with
//               NUM_BTN=4, DEBOUNCE_CYCLES=4. A cycle-accurate vector table
//               covers reset and a clean press; hand-written sequences cover
//               bounce, round-robin order, backpressure/drop and reset
//               during an offer.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_drop;
  logic [3:0] btn_level;

  always #5 clk = ~clk;

  button_event_arbiter #(
    .NUM_BTN        (4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .evt_ready(evt_ready),
    .evt_valid(evt_valid),
    .evt_id   (evt_id),
    .evt_drop (evt_drop),
    .btn_level(btn_level)
  );

  int total = 0;
  int bad   = 0;

  // Handshake and drop monitor, sampled mid-cycle.
  int ev_ids[$];
  int drop_cnt = 0;
  always @(negedge clk) begin
    if (rst && evt_valid && evt_ready) ev_ids.push_back(int'(evt_id));
    if (evt_drop) drop_cnt++;
  end

  typedef struct {
    logic       rst;
    logic [3:0] raw;
    logic       rdy;
    int         rep;
    logic       valid;
    logic [1:0] id;
    logic       drop;
    logic [3:0] level;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [3:0] raw, input logic rdy, input int n);
    for (int i = 0; i < n; i++) begin
      rst = 1'b1; btn_raw = raw; evt_ready = rdy;
      tick();
    end
  endtask

  function automatic int ev_at(input int idx);
    return (ev_ids.size() > idx) ? ev_ids[idx] : -1;
  endfunction

  int b0;
  int d0;

  initial begin
    rst = 1'b0; btn_raw = 4'hF; evt_ready = 1'b1;

    //              rst   raw    rdy  rep  valid id     drop  level
    vt[0] = '{1'b0, 4'hF, 1'b1,  3, 1'b0, 2'd0, 1'b0, 4'h0}; // reset held
    vt[1] = '{1'b1, 4'h0, 1'b1,  1, 1'b0, 2'd0, 1'b0, 4'h0};
    vt[2] = '{1'b1, 4'h4, 1'b1,  5, 1'b0, 2'd0, 1'b0, 4'h0}; // press edges 1-5
    vt[3] = '{1'b1, 4'h4, 1'b1,  2, 1'b0, 2'd0, 1'b0, 4'h4}; // level up at edge 6
    vt[4] = '{1'b1, 4'h4, 1'b1,  1, 1'b1, 2'd2, 1'b0, 4'h4}; // offer after edge 8
    vt[5] = '{1'b1, 4'h4, 1'b1, 42, 1'b0, 2'd2, 1'b0, 4'h4}; // rest of 50-cycle hold
    vt[6] = '{1'b1, 4'h0, 1'b1,  5, 1'b0, 2'd2, 1'b0, 4'h4}; // release edges 1-5
    vt[7] = '{1'b1, 4'h0, 1'b1, 10, 1'b0, 2'd2, 1'b0, 4'h0}; // level down, no event

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < vt[r].rep; k++) begin
        rst = vt[r].rst; btn_raw = vt[r].raw; evt_ready = vt[r].rdy;
        tick();
        chk($sformatf("row%0d.%0d valid", r, k), int'(evt_valid), int'(vt[r].valid));
        chk($sformatf("row%0d.%0d id",    r, k), int'(evt_id),    int'(vt[r].id));
        chk($sformatf("row%0d.%0d drop",  r, k), int'(evt_drop),  int'(vt[r].drop));
        chk($sformatf("row%0d.%0d level", r, k), int'(btn_level), int'(vt[r].level));
      end
    end
    chk("clean_press_events", ev_ids.size(), 1);
    chk("clean_press_id", ev_at(0), 2);

    // Bounce on channel 1 shorter than the debounce window, then a steady hold.
    b0 = ev_ids.size(); d0 = drop_cnt;
    for (int c = 0; c < 20; c++) run(((c / 2) % 2 == 0) ? 4'b0010 : 4'b0000, 1'b1, 1);
    run(4'b0010, 1'b1, 20);
    chk("bounce_level", int'(btn_level), 2);
    run(4'b0000, 1'b1, 15);
    chk("bounce_events", ev_ids.size() - b0, 1);
    chk("bounce_id", ev_at(b0), 1);
    chk("bounce_drops", drop_cnt - d0, 0);

    // Round-robin: 1 alone moves the pointer to 2, then 0 and 3 together.
    b0 = ev_ids.size();
    run(4'b0010, 1'b1, 12);
    run(4'b0000, 1'b1, 12);
    run(4'b1001, 1'b1, 12);
    run(4'b0000, 1'b1, 12);
    chk("rr_events", ev_ids.size() - b0, 3);
    chk("rr_id0", ev_at(b0), 1);
    chk("rr_id1", ev_at(b0 + 1), 3);
    chk("rr_id2", ev_at(b0 + 2), 0);

    // Backpressure: offer, pending, then a dropped third press.
    b0 = ev_ids.size(); d0 = drop_cnt;
    run(4'b0001, 1'b0, 12);
    chk("bp_offer_valid", int'(evt_valid), 1);
    chk("bp_offer_id", int'(evt_id), 0);
    run(4'b0000, 1'b0, 12);
    run(4'b0001, 1'b0, 12);
    run(4'b0000, 1'b0, 12);
    chk("bp_second_nodrop", drop_cnt - d0, 0);
    run(4'b0001, 1'b0, 12);
    run(4'b0000, 1'b0, 12);
    chk("bp_drop_pulses", drop_cnt - d0, 1);
    chk("bp_hold_valid", int'(evt_valid), 1);
    chk("bp_hold_id", int'(evt_id), 0);
    run(4'b0000, 1'b1, 10);
    chk("bp_events", ev_ids.size() - b0, 2);
    chk("bp_ev0", ev_at(b0), 0);
    chk("bp_ev1", ev_at(b0 + 1), 0);
    chk("bp_idle_after", int'(evt_valid), 0);

    // Reset during an offer with another channel still pending.
    run(4'b0110, 1'b0, 12);
    run(4'b0000, 1'b0, 12);
    chk("rst_pre_valid", int'(evt_valid), 1);
    chk("rst_pre_id", int'(evt_id), 1);
    rst = 1'b0; btn_raw = 4'b0000; evt_ready = 1'b0;
    tick();
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_id", int'(evt_id), 0);
    chk("rst_level", int'(btn_level), 0);
    b0 = ev_ids.size();
    run(4'b0000, 1'b0, 3);
    chk("rst_no_reoffer", int'(evt_valid), 0);
    run(4'b0000, 1'b1, 10);
    chk("rst_no_replay", ev_ids.size() - b0, 0);
    run(4'b1000, 1'b1, 12);
    run(4'b0000, 1'b1, 12);
    chk("rst_after_events", ev_ids.size() - b0, 1);
    chk("rst_after_id", ev_at(b0), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_button_event_arbiter
`default_nettype wire
